// File: rtl/wb_stage_reg.sv
// MEM/WB pipeline register with write-back source select, load extension and retired-write counter; 1-cycle latency, stall holds / flush clears.
// Optional EX-stage forwarding taps (fwd_rs1/2 -> fwd_hit1/2, fwd_data) are built only when WB_FWD_EN is defined.
module wb_stage_reg #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    input  logic              mem_valid,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_we,
    input  logic [1:0]        mem_wd_sel,
    input  logic [2:0]        mem_ld_type,
    input  logic [XLEN-1:0]   mem_pc4,
    input  logic [XLEN-1:0]   mem_aluc,
    input  logic [XLEN-1:0]   mem_dm,
    input  logic [XLEN-1:0]   mem_imm,
    input  logic              wb_stall,
    input  logic              wb_flush,
`ifdef WB_FWD_EN
    input  logic [REG_AW-1:0] fwd_rs1,
    input  logic [REG_AW-1:0] fwd_rs2,
    output logic              fwd_hit1,
    output logic              fwd_hit2,
    output logic [XLEN-1:0]   fwd_data,
`endif
    output logic              wb_valid,
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_rd,
    output logic [XLEN-1:0]   wb_wdata,
    output logic [CNT_W-1:0]  wb_retired
);

    logic              valid_q, valid_d;
    logic              we_q, we_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]  retired_q, retired_d;

    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [XLEN-1:0]   ld_val;
    logic [XLEN-1:0]   sel_val;

    always_comb begin
        case (mem_aluc[1:0])
            2'd0:    ld_byte = mem_dm[7:0];
            2'd1:    ld_byte = mem_dm[15:8];
            2'd2:    ld_byte = mem_dm[23:16];
            default: ld_byte = mem_dm[31:24];
        endcase
        // Misaligned halfwords are not trapped here: only off[1] picks the half.
        ld_half = mem_aluc[1] ? mem_dm[31:16] : mem_dm[15:0];

        case (mem_ld_type)
            3'b000:  ld_val = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b001:  ld_val = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b100:  ld_val = {{(XLEN-8){1'b0}}, ld_byte};
            3'b101:  ld_val = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_val = mem_dm;
        endcase

        case (mem_wd_sel)
            2'b00:   sel_val = mem_pc4;
            2'b01:   sel_val = mem_aluc;
            2'b10:   sel_val = ld_val;
            default: sel_val = mem_imm;
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        we_d    = we_q;
        rd_d    = rd_q;
        wdata_d = wdata_q;
        if (wb_flush) begin
            valid_d = 1'b0;
            we_d    = 1'b0;
            rd_d    = '0;
            wdata_d = '0;
        end else if (!wb_stall) begin
            valid_d = mem_valid;
            we_d    = mem_valid & mem_we & (mem_rd != '0);
            rd_d    = mem_rd;
            wdata_d = sel_val;
        end

        // A write commits when it leaves WB; a same-edge flush cannot undo it.
        retired_d = retired_q;
        if (we_q && !wb_stall)
            retired_d = retired_q + CNT_W'(1);
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            valid_q   <= 1'b0;
            we_q      <= 1'b0;
            rd_q      <= '0;
            wdata_q   <= '0;
            retired_q <= '0;
        end else begin
            valid_q   <= valid_d;
            we_q      <= we_d;
            rd_q      <= rd_d;
            wdata_q   <= wdata_d;
            retired_q <= retired_d;
        end
    end

    assign wb_valid   = valid_q;
    assign wb_we      = we_q;
    assign wb_rd      = rd_q;
    assign wb_wdata   = wdata_q;
    assign wb_retired = retired_q;

`ifdef WB_FWD_EN
    assign fwd_hit1 = we_q & (rd_q == fwd_rs1);
    assign fwd_hit2 = we_q & (rd_q == fwd_rs2);
    assign fwd_data = wdata_q;
`endif

endmodule

// File: tb/tb_wb_stage_reg.sv
// Directed-vector bench for wb_stage_reg with a queue scoreboard checked once per cycle.
module tb_wb_stage_reg;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst = 1'b1;
    logic        mem_valid = 1'b0;
    logic [4:0]  mem_rd = '0;
    logic        mem_we = 1'b0;
    logic [1:0]  mem_wd_sel = '0;
    logic [2:0]  mem_ld_type = '0;
    logic [31:0] mem_pc4 = 32'h104;
    logic [31:0] mem_aluc = '0;
    logic [31:0] mem_dm = '0;
    logic [31:0] mem_imm = '0;
    logic        wb_stall = 1'b0;
    logic        wb_flush = 1'b0;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_wdata;
    logic [3:0]  wb_retired;
`ifdef WB_FWD_EN
    logic [4:0]  fwd_rs1 = '0;
    logic [4:0]  fwd_rs2 = '0;
    logic        fwd_hit1;
    logic        fwd_hit2;
    logic [31:0] fwd_data;
`endif

    wb_stage_reg #(.XLEN(32), .REG_AW(5), .CNT_W(4)) dut (
        .cpu_clk     (cpu_clk),
        .cpu_rst     (cpu_rst),
        .mem_valid   (mem_valid),
        .mem_rd      (mem_rd),
        .mem_we      (mem_we),
        .mem_wd_sel  (mem_wd_sel),
        .mem_ld_type (mem_ld_type),
        .mem_pc4     (mem_pc4),
        .mem_aluc    (mem_aluc),
        .mem_dm      (mem_dm),
        .mem_imm     (mem_imm),
        .wb_stall    (wb_stall),
        .wb_flush    (wb_flush),
`ifdef WB_FWD_EN
        .fwd_rs1     (fwd_rs1),
        .fwd_rs2     (fwd_rs2),
        .fwd_hit1    (fwd_hit1),
        .fwd_hit2    (fwd_hit2),
        .fwd_data    (fwd_data),
`endif
        .wb_valid    (wb_valid),
        .wb_we       (wb_we),
        .wb_rd       (wb_rd),
        .wb_wdata    (wb_wdata),
        .wb_retired  (wb_retired)
    );

    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        logic        v;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic [3:0]  ret;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic        m_we  = 1'b0;
    logic [3:0]  m_ret = '0;
    logic [4:0]  cur_rs1 = '0;
    logic [4:0]  cur_rs2 = '0;
    localparam logic [31:0] DM = 32'h80F1_7F82;

    task automatic chk(input string name, input string field, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got 0x%08h expected 0x%08h", name, field, act, exp);
        end
    endtask

    // Monitor: one expectation per clock, compared after the edge that produced it.
    always @(negedge cpu_clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_vec++;
            chk(e.name, "valid",   {31'b0, wb_valid}, {31'b0, e.v});
            chk(e.name, "we",      {31'b0, wb_we},    {31'b0, e.we});
            chk(e.name, "rd",      {27'b0, wb_rd},    {27'b0, e.rd});
            chk(e.name, "wdata",   wb_wdata,          e.wd);
            chk(e.name, "retired", {28'b0, wb_retired}, {28'b0, e.ret});
`ifdef WB_FWD_EN
            chk(e.name, "hit1", {31'b0, fwd_hit1}, {31'b0, e.we && (e.rd == e.rs1)});
            chk(e.name, "hit2", {31'b0, fwd_hit2}, {31'b0, e.we && (e.rd == e.rs2)});
            chk(e.name, "fwd_data", fwd_data, e.wd);
`endif
        end
    end

    task automatic vec(input string name,
                       input logic rst, input logic stall, input logic flush,
                       input logic v, input logic we, input logic [4:0] rd,
                       input logic [1:0] sel, input logic [2:0] ldt,
                       input logic [31:0] aluc, input logic [31:0] dm, input logic [31:0] imm,
                       input logic ev, input logic ewe, input logic [4:0] erd, input logic [31:0] ewd);
        exp_t e;
        @(negedge cpu_clk);
        #1;
        cpu_rst = rst; wb_stall = stall; wb_flush = flush;
        mem_valid = v; mem_we = we; mem_rd = rd; mem_wd_sel = sel; mem_ld_type = ldt;
        mem_aluc = aluc; mem_dm = dm; mem_imm = imm;
`ifdef WB_FWD_EN
        fwd_rs1 = cur_rs1; fwd_rs2 = cur_rs2;
`endif
        if (rst)
            m_ret = '0;
        else if (m_we && !stall)
            m_ret = m_ret + 4'd1;
        m_we = rst ? 1'b0 : ewe;
        e.v = ev; e.we = ewe; e.rd = erd; e.wd = ewd; e.ret = m_ret;
        e.rs1 = cur_rs1; e.rs2 = cur_rs2; e.name = name;
        sb.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end of the vector list");
        $fatal(1, "timeout");
    end

    initial begin
        //        name      rst stl fl v  we rd    sel    ldt     aluc           dm            imm             ev we erd   wdata
        vec("rst0",     1, 0, 0, 1, 1, 5'd5, 2'b01, 3'b010, 32'hDEAD0000, DM, 32'h7FF,       0, 0, 5'd0, 32'h0);
        vec("rst1",     1, 1, 1, 1, 1, 5'd5, 2'b01, 3'b010, 32'hDEAD0000, DM, 32'h7FF,       0, 0, 5'd0, 32'h0);
        vec("sel_pc4",  0, 0, 0, 1, 1, 5'd5, 2'b00, 3'b010, 32'hDEAD0000, DM, 32'h7FF,       1, 1, 5'd5, 32'h104);
        vec("sel_alu",  0, 0, 0, 1, 1, 5'd5, 2'b01, 3'b010, 32'hDEAD0000, DM, 32'h7FF,       1, 1, 5'd5, 32'hDEAD0000);
        vec("sel_imm",  0, 0, 0, 1, 1, 5'd5, 2'b11, 3'b010, 32'hDEAD0000, DM, 32'h7FF,       1, 1, 5'd5, 32'h7FF);
        vec("lb_0",     0, 0, 0, 1, 1, 5'd6, 2'b10, 3'b000, 32'h1000, DM, 32'h0,             1, 1, 5'd6, 32'hFFFFFF82);
        vec("lbu_0",    0, 0, 0, 1, 1, 5'd6, 2'b10, 3'b100, 32'h1000, DM, 32'h0,             1, 1, 5'd6, 32'h00000082);
        vec("lb_1",     0, 0, 0, 1, 1, 5'd6, 2'b10, 3'b000, 32'h1001, DM, 32'h0,             1, 1, 5'd6, 32'h0000007F);
        vec("lh_2",     0, 0, 0, 1, 1, 5'd6, 2'b10, 3'b001, 32'h1002, DM, 32'h0,             1, 1, 5'd6, 32'hFFFF80F1);
        vec("lhu_2",    0, 0, 0, 1, 1, 5'd6, 2'b10, 3'b101, 32'h1002, DM, 32'h0,             1, 1, 5'd6, 32'h000080F1);
        vec("lw",       0, 0, 0, 1, 1, 5'd6, 2'b10, 3'b010, 32'h1002, DM, 32'h0,             1, 1, 5'd6, 32'h80F17F82);
        vec("lh_3",     0, 0, 0, 1, 1, 5'd6, 2'b10, 3'b001, 32'h1003, DM, 32'h0,             1, 1, 5'd6, 32'hFFFF80F1);
        vec("lbu_3",    0, 0, 0, 1, 1, 5'd6, 2'b10, 3'b100, 32'h1003, DM, 32'h0,             1, 1, 5'd6, 32'h00000080);
        vec("lb_2",     0, 0, 0, 1, 1, 5'd6, 2'b10, 3'b000, 32'h1002, DM, 32'h0,             1, 1, 5'd6, 32'hFFFFFFF1);
        vec("lhu_1",    0, 0, 0, 1, 1, 5'd6, 2'b10, 3'b101, 32'h1001, DM, 32'h0,             1, 1, 5'd6, 32'h00007F82);
        vec("ld_undef", 0, 0, 0, 1, 1, 5'd6, 2'b10, 3'b011, 32'h1001, DM, 32'h0,             1, 1, 5'd6, 32'h80F17F82);
        cur_rs1 = 5'd0; cur_rs2 = 5'd3;
        vec("x0",       0, 0, 0, 1, 1, 5'd0, 2'b11, 3'b010, 32'h0, DM, 32'h55,               1, 0, 5'd0, 32'h55);
        vec("invalid",  0, 0, 0, 0, 1, 5'd3, 2'b11, 3'b010, 32'h0, DM, 32'h66,               0, 0, 5'd3, 32'h66);
        cur_rs1 = 5'd7; cur_rs2 = 5'd8;
        vec("ld_rd7",   0, 0, 0, 1, 1, 5'd7, 2'b11, 3'b010, 32'h0, DM, 32'h11,               1, 1, 5'd7, 32'h11);
        for (int i = 0; i < 3; i++)
            vec("stall",0, 1, 0, 1, 1, 5'd8, 2'b11, 3'b010, 32'h0, DM, 32'h22,               1, 1, 5'd7, 32'h11);
        vec("unstall",  0, 0, 0, 1, 1, 5'd8, 2'b11, 3'b010, 32'h0, DM, 32'h22,               1, 1, 5'd8, 32'h22);
        vec("stl_fl",   0, 1, 1, 1, 1, 5'd9, 2'b11, 3'b010, 32'h0, DM, 32'h33,               0, 0, 5'd0, 32'h0);
        vec("ld_rd9",   0, 0, 0, 1, 1, 5'd9, 2'b11, 3'b010, 32'h0, DM, 32'h33,               1, 1, 5'd9, 32'h33);
        vec("flush",    0, 0, 1, 1, 1, 5'd10, 2'b11, 3'b010, 32'h0, DM, 32'h44,              0, 0, 5'd0, 32'h0);
        cur_rs1 = 5'd9; cur_rs2 = 5'd0;
        for (int i = 0; i < 20; i++)
            vec("wrap", 0, 0, 0, 1, 1, 5'd9, 2'b11, 3'b010, 32'h0, DM, 32'(i + 256),         1, 1, 5'd9, 32'(i + 256));
        vec("idle",     0, 0, 0, 0, 0, 5'd0, 2'b00, 3'b010, 32'h0, DM, 32'h0,                0, 0, 5'd0, 32'h104);
        for (int i = 0; i < 10 && sb.size() > 0; i++)
            @(negedge cpu_clk);
        #1;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
